// File: rtl/shift_seq.sv
// Parallel-to-serial sequencer for a WIDTH-stage serial-in shift register:
// accepts a word, pulses a clear, shifts the word in, then reports the readback and a mismatch flag.
module shift_seq #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_clr,
  output logic             sr_en,
  output logic             sr_si,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       gap_q;
  logic [WIDTH-1:0] latch_q;
  logic             sr_clr_q;
  logic             sr_en_q;
  logic             sr_si_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_err_q;
  logic [WIDTH-1:0] order_s;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  function automatic logic ser_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
    logic [WIDTH-1:0] sh;
    sh = w >> idx;
    return sh[0];
  endfunction

  // Bit i of order_s is the i-th bit shifted out; it is also the image the register must hold.
  always_comb begin
    order_s = latch_q;
    if (LSB_FIRST) begin
      order_s = latch_q;
    end else begin
      order_s = bit_rev(latch_q);
    end
  end

  // Sequencer FSM with registered strobes and result.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      gap_q       <= 4'd0;
      latch_q     <= '0;
      sr_clr_q    <= 1'b0;
      sr_en_q     <= 1'b0;
      sr_si_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            latch_q  <= in_data;
            sr_clr_q <= 1'b1;
            state_q  <= S_CLR;
          end
        end
        S_CLR: begin
          sr_clr_q <= 1'b0;
          cnt_q    <= CNT_ZERO;
          sr_en_q  <= 1'b1;
          sr_si_q  <= ser_bit(order_s, CNT_ZERO);
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            sr_en_q <= 1'b0;
            sr_si_q <= 1'b0;
            state_q <= S_DONE;
          end else begin
            sr_si_q <= ser_bit(order_s, cnt_q + CNT_ONE);
          end
        end
        // First DONE cycle samples sr_q once the final shift has landed.
        S_DONE: begin
          if (!out_valid_q) begin
            out_data_q  <= sr_q;
            out_err_q   <= (sr_q != order_s);
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            gap_q       <= 4'd0;
            state_q     <= (GAP > 0) ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          sr_clr_q    <= 1'b0;
          sr_en_q     <= 1'b0;
          sr_si_q     <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign sr_clr    = sr_clr_q;
  assign sr_en     = sr_en_q;
  assign sr_si     = sr_si_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: instance 0 is LSB-first with no gap, instance 1 is MSB-first with GAP = 2;
// each drives a behavioural shift register whose readback can carry stuck-at-0 bits.
module tb_shift_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clear;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_data   [2];
  logic         sr_clr    [2];
  logic         sr_en     [2];
  logic         sr_si     [2];
  logic [W-1:0] sr_q      [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_data  [2];
  logic         out_err   [2];
  logic         busy      [2];
  logic [W-1:0] reg_q     [2];
  logic [W-1:0] stuck     [2];

  int n_chk  = 0;
  int n_pass = 0;

  shift_seq #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP(0)) dut_lsb (
    .clk(clk), .clear(clear), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .sr_clr(sr_clr[0]), .sr_en(sr_en[0]), .sr_si(sr_si[0]),
    .sr_q(sr_q[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_err(out_err[0]), .busy(busy[0])
  );

  shift_seq #(.WIDTH(W), .LSB_FIRST(1'b0), .GAP(2)) dut_msb (
    .clk(clk), .clear(clear), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .sr_clr(sr_clr[1]), .sr_en(sr_en[1]), .sr_si(sr_si[1]),
    .sr_q(sr_q[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_err(out_err[1]), .busy(busy[1])
  );

  // Serial-in register: new bit enters at the top, so q[0] ends up holding the oldest bit.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (sr_clr[g]) reg_q[g] <= '0;
      else if (sr_en[g]) reg_q[g] <= {sr_si[g], reg_q[g][W-1:1]};
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) sr_q[g] = reg_q[g] & ~stuck[g];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: bit i of the result is the i-th bit sent, which is also where it lands in the register.
  function automatic logic [W-1:0] send_order(input int k, input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (k == 0) ? d[i] : d[W-1-i];
    return r;
  endfunction

  // One complete word on instance k, checked cycle by cycle; starts and ends at a falling edge.
  task automatic run_word(input int k, input logic [W-1:0] d, input logic [W-1:0] mask,
                          input int bp, input logic [W-1:0] e_ser,
                          input logic [W-1:0] e_out, input logic e_err);
    int gap;
    gap          = (k == 0) ? 0 : 2;
    stuck[k]     = mask;
    in_data[k]   = d;
    in_valid[k]  = 1'b1;
    out_ready[k] = (bp == 0);
    chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
    @(negedge clk);
    in_data[k] = ~d;  // held valid with different data: must not be re-latched
    chk("clr_pulse", 32'(sr_clr[k]), 32'd1);
    chk("clr_no_en", 32'(sr_en[k]), 32'd0);
    chk("busy_clr", 32'(busy[k]), 32'd1);
    chk("in_ready_clr", 32'(in_ready[k]), 32'd0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("shift_en", 32'(sr_en[k]), 32'd1);
      chk("shift_no_clr", 32'(sr_clr[k]), 32'd0);
      chk("shift_si", 32'(sr_si[k]), 32'(e_ser[i]));
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    chk("done_no_en", 32'(sr_en[k]), 32'd0);
    chk("done_pre_valid", 32'(out_valid[k]), 32'd0);
    @(negedge clk);
    chk("out_valid", 32'(out_valid[k]), 32'd1);
    chk("out_data", 32'(out_data[k]), 32'(e_out));
    chk("out_err", 32'(out_err[k]), 32'(e_err));
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid[k]), 32'd1);
      chk("hold_data", 32'(out_data[k]), 32'(e_out));
      chk("hold_err", 32'(out_err[k]), 32'(e_err));
      chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
      chk("hold_busy", 32'(busy[k]), 32'd1);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("valid_drop", 32'(out_valid[k]), 32'd0);
    for (int g = 0; g < gap; g++) begin
      chk("gap_in_ready", 32'(in_ready[k]), 32'd0);
      chk("gap_busy", 32'(busy[k]), 32'd1);
      @(negedge clk);
    end
    chk("idle_in_ready", 32'(in_ready[k]), 32'd1);
    chk("idle_busy", 32'(busy[k]), 32'd0);
  endtask

  typedef struct {
    int           k;
    logic [W-1:0] d;
    logic [W-1:0] mask;
    int           bp;
    logic [W-1:0] e_ser;
    logic [W-1:0] e_out;
    logic         e_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 4'b1011, 4'b0000, 0, 4'b1011, 4'b1011, 1'b0};
    vecs[1] = '{1, 4'b1000, 4'b0000, 0, 4'b0001, 4'b0001, 1'b0};
    vecs[2] = '{0, 4'b0100, 4'b0100, 0, 4'b0100, 4'b0000, 1'b1};
    vecs[3] = '{0, 4'b1011, 4'b0000, 5, 4'b1011, 4'b1011, 1'b0};
    vecs[4] = '{0, 4'b0110, 4'b0000, 0, 4'b0110, 4'b0110, 1'b0};
    vecs[5] = '{1, 4'b1101, 4'b0100, 2, 4'b1011, 4'b1011, 1'b0};

    clear = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b1;
      in_data[g]   = 4'b1010;
      out_ready[g] = 1'b1;
      stuck[g]     = 4'b0000;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_in_ready", 32'(in_ready[g]), 32'd1);
      chk("rst_busy", 32'(busy[g]), 32'd0);
      chk("rst_sr_clr", 32'(sr_clr[g]), 32'd0);
      chk("rst_sr_en", 32'(sr_en[g]), 32'd0);
      chk("rst_sr_si", 32'(sr_si[g]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[g]), 32'd0);
      chk("rst_out_data", 32'(out_data[g]), 32'd0);
      chk("rst_out_err", 32'(out_err[g]), 32'd0);
    end
    in_valid[1] = 1'b0;
    clear = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_word(vecs[v].k, vecs[v].d, vecs[v].mask, vecs[v].bp,
               vecs[v].e_ser, vecs[v].e_out, vecs[v].e_err);
    end

    // Abort during the second shift cycle, then a clean word.
    stuck[0]    = 4'b0000;
    in_data[0]  = 4'b0011;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_en", 32'(sr_en[0]), 32'd1);
    #2 clear = 1'b0;
    #1;
    chk("abort_en", 32'(sr_en[0]), 32'd0);
    chk("abort_clr", 32'(sr_clr[0]), 32'd0);
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_valid", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    run_word(0, 4'b1111, 4'b0000, 0, 4'b1111, 4'b1111, 1'b0);

    for (int r = 0; r < 24; r++) begin
      int           k;
      int           bp;
      logic [W-1:0] d;
      logic [W-1:0] mask;
      logic [W-1:0] img;
      k    = int'($urandom_range(1, 0));
      bp   = int'($urandom_range(3, 0));
      d    = W'($urandom);
      mask = ($urandom_range(3, 0) == 0) ? W'(1 << $urandom_range(W - 1, 0)) : '0;
      img  = send_order(k, d);
      run_word(k, d, mask, bp, img, img & ~mask, |(img & mask));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
